instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Fetch stage that drives the program counter into the 256x16 instruction memory and consumes the instruction the memory returns. The memory read is combinational: instr = mem[PC] within the same cycle. Each cycle the unit registers instr and PC into a fetch/decode pipeline register. It handles stall, branch/jump redirect, and halt, and sits between instruction memory and the decode/control logic.

Parameters:
PC_WIDTH, 8, PC / memory address width; increment wraps modulo 2^PC_WIDTH
INSTR_WIDTH, 16, instruction word width
RESET_PC, 8'h00, PC value loaded on reset
HALT_OPCODE, 4'hF, value of instr[15:12] that marks a halt instruction

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
PC  output  PC_WIDTH  address to instruction memory
instr  input  INSTR_WIDTH  combinational read data for mem[PC]
stall  input  1  decode not ready; hold the pipeline register and PC
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  PC_WIDTH  target address, valid when redirect_valid=1
if_valid  output  1  if_instr and if_pc hold a valid instruction
if_instr  output  INSTR_WIDTH  registered instruction
if_pc  output  PC_WIDTH  address if_instr was fetched from
halted  output  1  unit is in HALT

Behaviour:
- Interface (decided): one clock, clk; rst is asynchronous, active-high.
- Reset values: PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, state=FETCH. Reset asserted mid-operation discards any in-flight instruction immediately.
- FSM states: FETCH and HALT.
- FETCH, priority order (highest first):
  - redirect_valid=1:
    - PC<=redirect_pc, if_valid<=0 (one bubble), if_instr and if_pc unchanged.
    - Redirect overrides a simultaneous stall.
    - A halt opcode on instr in that cycle is ignored, because it is on the squashed path.
  - stall=1:
    - PC, if_valid, if_instr, if_pc all hold.
    - No halt detection in this cycle.
  - Otherwise:
    - if_instr<=instr, if_pc<=PC, if_valid<=1.
    - PC<=PC+1, wrapping 8'hFF->8'h00 with no flag.
    - If instr[15:12]==HALT_OPCODE: go to HALT, and PC holds (no increment).
- Latency: an instruction at address A appears on if_instr one cycle after PC==A, provided there is no stall or redirect in that cycle.
- HALT state:
  - halted=1 starting from the first cycle in HALT.
  - The halt instruction stays presented (if_valid=1) until a cycle with stall=0. At that clock edge if_valid<=0, and it remains 0 afterward.
  - PC frozen. redirect_valid and stall ignored except as described above.
  - Exit only via rst.
- Back-to-back redirects: each one reloads PC and produces a bubble, with no accumulation.
- redirect_pc equal to the current PC is legal and refetches the same address after a bubble.

Optional Feature:
Macro IFETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [15:0] and output bubble_count [15:0], both reset to 0.
  - fetch_count increments on every clock edge where if_valid=1 and stall=0 (instruction consumed).
  - bubble_count increments on every redirect accepted in FETCH.
  - Both counters saturate at 16'hFFFF.
- Not defined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then free run, memory holding 16'h1000+addr at each address -> PC=0,1,2...; if_instr=16'h1000 one cycle after PC=0 with if_pc=0 and if_valid=1; PC sequence continues.
- Free run through wrap, no halt opcodes present -> PC goes 8'hFE, 8'hFF, 8'h00; if_pc goes 8'hFF then 8'h00; if_valid stays 1 throughout.
- stall high for 3 cycles while if_instr=16'h1005 -> PC, if_instr and if_pc stay constant for 3 cycles; fetch resumes at 6 one cycle after stall drops.
- redirect_valid=1, redirect_pc=8'h40 asserted together with stall=1 at PC=8'h10 -> next cycle PC=8'h40 and if_valid=0; following cycle if_instr=mem[0x40] and if_pc=8'h40.
- mem[3]=16'hF000, stall=1 on the cycle after the halt is registered -> halted=1, if_instr=16'hF000 with if_valid=1 held during the stall, if_valid=0 after stall drops, PC stays at 3; assert rst -> PC=RESET_PC and halted=0.
- With IFETCH_PERF_CNT_EN defined: 5 consumed instructions plus 2 redirects -> fetch_count=5, bubble_count=2; both counters read 0 after rst.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives PC into a combinational instruction memory and registers the returned word.
// Optional fetch/bubble performance counters are built when IFETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
   parameter int                  PC_WIDTH    = 8,
   parameter int                  INSTR_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = 8'h00,
   parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PC_WIDTH-1:0]    PC,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   if_valid,
   output logic [INSTR_WIDTH-1:0] if_instr,
   output logic [PC_WIDTH-1:0]    if_pc,
   output logic                   halted
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [15:0]            fetch_count,
   output logic [15:0]            bubble_count
`endif
);

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HALT  = 1'b1
   } state_t;

   state_t state_r;

   function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] word);
      return (word[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
   endfunction

   // PC, pipeline register, halt flag and fetch state machine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= FETCH;
         PC       <= RESET_PC;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
         halted   <= 1'b0;
      end else begin
         case (state_r)
            FETCH: begin
               if (redirect_valid) begin
                  // redirect wins over stall; the word on instr is on the squashed path
                  PC       <= redirect_pc;
                  if_valid <= 1'b0;
               end else if (stall) begin
                  PC       <= PC;
                  if_valid <= if_valid;
               end else begin
                  if_instr <= instr;
                  if_pc    <= PC;
                  if_valid <= 1'b1;
                  if (is_halt(instr)) begin
                     state_r <= HALT;
                     halted  <= 1'b1;
                  end else begin
                     PC <= PC + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                  end
               end
            end
            HALT: begin
               halted <= 1'b1;
               // halt word stays presented until decode accepts it
               if (!stall) begin
                  if_valid <= 1'b0;
               end else begin
                  if_valid <= if_valid;
               end
            end
            default: begin
               state_r  <= FETCH;
               PC       <= RESET_PC;
               if_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         return value;
      end else begin
         return value + 16'h0001;
      end
   endfunction

   // consumed-instruction and redirect-bubble counters, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count  <= 16'h0000;
         bubble_count <= 16'h0000;
      end else begin
         if (if_valid && !stall) begin
            fetch_count <= sat_inc(fetch_count);
         end else begin
            fetch_count <= fetch_count;
         end
         if ((state_r == FETCH) && redirect_valid) begin
            bubble_count <= sat_inc(bubble_count);
         end else begin
            bubble_count <= bubble_count;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit with a behavioural instruction memory.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  PC;
   logic [15:0] instr;
   logic        stall;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [7:0]  if_pc;
   logic        halted;
`ifdef IFETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
   logic [15:0] bubble_count;
`endif

   logic [15:0] mem [0:255];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign instr = mem[PC];

   instruction_fetch_unit dut (
      .clk(clk),
      .rst(rst),
      .PC(PC),
      .instr(instr),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .if_valid(if_valid),
      .if_instr(if_instr),
      .if_pc(if_pc),
      .halted(halted)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .fetch_count(fetch_count),
      .bubble_count(bubble_count)
`endif
   );

   typedef struct {
      logic        stall;
      logic        rv;
      logic [7:0]  rpc;
      logic [7:0]  pc;
      logic        valid;
      logic [15:0] ins;
      logic [7:0]  ipc;
      logic        hlt;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(input logic s, input logic rv, input logic [7:0] rpc,
                               input logic [7:0] pc, input logic v, input logic [15:0] ins,
                               input logic [7:0] ipc, input logic h);
      vec_t r;
      r.stall = s; r.rv = rv; r.rpc = rpc; r.pc = pc;
      r.valid = v; r.ins = ins; r.ipc = ipc; r.hlt = h;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] pc, input logic v,
                            input logic [15:0] ins, input logic [7:0] ipc, input logic h);
      chk({tag, ".PC"}, {24'h0, PC}, {24'h0, pc});
      chk({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, v});
      if (v) chk({tag, ".if_instr"}, {16'h0, if_instr}, {16'h0, ins});
      if (v) chk({tag, ".if_pc"}, {24'h0, if_pc}, {24'h0, ipc});
      chk({tag, ".halted"}, {31'h0, halted}, {31'h0, h});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic rv, input logic [7:0] rpc);
      stall = s;
      redirect_valid = rv;
      redirect_pc = rpc;
   endtask

   // asynchronous reset: outputs must clear without any clock edge
   task automatic do_reset(input string tag);
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      #2;
      chk({tag, ".PC"}, {24'h0, PC}, 32'h0);
      chk({tag, ".if_valid"}, {31'h0, if_valid}, 32'h0);
      chk({tag, ".if_instr"}, {16'h0, if_instr}, 32'h0);
      chk({tag, ".if_pc"}, {24'h0, if_pc}, 32'h0);
      chk({tag, ".halted"}, {31'h0, halted}, 32'h0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);

      // free run, 3-cycle stall, redirect+stall, same-PC redirect, back-to-back redirects, wrap
      vecs[0]  = mk(1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 16'h1000, 8'h00, 1'b0);
      vecs[1]  = mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 16'h1001, 8'h01, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 16'h1002, 8'h02, 1'b0);
      vecs[3]  = mk(1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 16'h1003, 8'h03, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 8'h00, 8'h05, 1'b1, 16'h1004, 8'h04, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 8'h00, 8'h06, 1'b1, 16'h1005, 8'h05, 1'b0);
      vecs[6]  = mk(1'b1, 1'b0, 8'h00, 8'h06, 1'b1, 16'h1005, 8'h05, 1'b0);
      vecs[7]  = mk(1'b1, 1'b0, 8'h00, 8'h06, 1'b1, 16'h1005, 8'h05, 1'b0);
      vecs[8]  = mk(1'b1, 1'b0, 8'h00, 8'h06, 1'b1, 16'h1005, 8'h05, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 8'h00, 8'h07, 1'b1, 16'h1006, 8'h06, 1'b0);
      vecs[10] = mk(1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 16'h1006, 8'h06, 1'b0);
      vecs[11] = mk(1'b1, 1'b1, 8'h40, 8'h40, 1'b0, 16'h1006, 8'h06, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 8'h00, 8'h41, 1'b1, 16'h1040, 8'h40, 1'b0);
      vecs[13] = mk(1'b0, 1'b1, 8'h41, 8'h41, 1'b0, 16'h1040, 8'h40, 1'b0);
      vecs[14] = mk(1'b0, 1'b0, 8'h00, 8'h42, 1'b1, 16'h1041, 8'h41, 1'b0);
      vecs[15] = mk(1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 16'h1041, 8'h41, 1'b0);
      vecs[16] = mk(1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 16'h1041, 8'h41, 1'b0);
      vecs[17] = mk(1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 16'h10FE, 8'hFE, 1'b0);
      vecs[18] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h10FF, 8'hFF, 1'b0);
      vecs[19] = mk(1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 16'h1000, 8'h00, 1'b0);
      vecs[20] = mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 16'h1001, 8'h01, 1'b0);

      do_reset("reset0");
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc);
         step();
         check_out($sformatf("vec%0d", i), vecs[i].pc, vecs[i].valid, vecs[i].ins,
                   vecs[i].ipc, vecs[i].hlt);
      end

      // reset while a valid instruction is in flight
      do_reset("reset_mid");

      // halt at address 3, held by stall, redirect ignored while halted
      mem[3] = 16'hF000;
      drive(1'b0, 1'b0, 8'h00); step(); check_out("h1", 8'h01, 1'b1, 16'h1000, 8'h00, 1'b0);
      step(); check_out("h2", 8'h02, 1'b1, 16'h1001, 8'h01, 1'b0);
      step(); check_out("h3", 8'h03, 1'b1, 16'h1002, 8'h02, 1'b0);
      step(); check_out("h_halt", 8'h03, 1'b1, 16'hF000, 8'h03, 1'b1);
      drive(1'b1, 1'b0, 8'h00); step(); check_out("h_stall", 8'h03, 1'b1, 16'hF000, 8'h03, 1'b1);
      drive(1'b1, 1'b1, 8'h20); step(); check_out("h_redir", 8'h03, 1'b1, 16'hF000, 8'h03, 1'b1);
      drive(1'b0, 1'b0, 8'h00); step(); check_out("h_drop", 8'h03, 1'b0, 16'hF000, 8'h03, 1'b1);
      drive(1'b0, 1'b1, 8'h50); step(); check_out("h_frozen", 8'h03, 1'b0, 16'hF000, 8'h03, 1'b1);
      drive(1'b0, 1'b0, 8'h00); step(); check_out("h_frozen2", 8'h03, 1'b0, 16'hF000, 8'h03, 1'b1);
      do_reset("reset_halt");
      mem[3] = 16'h1003;
      step(); check_out("after_rst", 8'h01, 1'b1, 16'h1000, 8'h00, 1'b0);

`ifdef IFETCH_PERF_CNT_EN
      do_reset("reset_perf");
      chk("fetch_count_rst", {16'h0, fetch_count}, 32'h0);
      chk("bubble_count_rst", {16'h0, bubble_count}, 32'h0);
      // six fetches, five of them consumed (first edge had if_valid=0)
      for (int i = 0; i < 6; i++) step();
      drive(1'b1, 1'b1, 8'h30); step();
      drive(1'b0, 1'b1, 8'h60); step();
      chk("fetch_count", {16'h0, fetch_count}, 32'd5);
      chk("bubble_count", {16'h0, bubble_count}, 32'd2);
      do_reset("reset_perf2");
      chk("fetch_count_rst2", {16'h0, fetch_count}, 32'h0);
      chk("bubble_count_rst2", {16'h0, bubble_count}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
